// File: rtl/inst_share_pkg.sv
// Shared types and the round-robin pick helper for the shared-unit arbiter.
package inst_share_pkg;

  localparam int MAX_REQ = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int                 nreq);
    rr_pick_t           pick;
    int                 cand;
    logic [MAX_IDW-1:0] cand_idx;
    pick = '0;
    // Walk from the farthest offset to the nearest so the nearest valid requester wins.
    for (int off = MAX_REQ; off >= 1; off--) begin
      if (off <= nreq) begin
        cand     = (int'(ptr) + off) % nreq;
        cand_idx = MAX_IDW'(cand);
        if (valid[cand_idx]) begin
          pick.found = 1'b1;
          pick.idx   = cand_idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/inst_share_tagpipe.sv
// LAT-deep shift register of issue tags; the head entry lines up with unit_o.
module inst_share_tagpipe #(
  parameter int LAT = 2,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_vld,
  input  logic [IDW-1:0] push_id,
  output logic           out_vld,
  output logic [IDW-1:0] out_id,
  output logic           empty
);

  logic [LAT-1:0] vld;
  logic [IDW-1:0] ids [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= push_vld;
      for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: only the valid bits are reset; IDs are always qualified by their
  // valid bit, so the ID storage stays a plain reset-free shift register.
  always_ff @(posedge clk) begin
    ids[0] <= push_id;
    for (int i = 1; i < LAT; i++) ids[i] <= ids[i-1];
  end

  assign out_vld = vld[LAT-1];
  assign out_id  = ids[LAT-1];
  assign empty   = ~|vld;

endmodule

// File: rtl/inst_share_arb.sv
// Round-robin arbiter sharing one fixed-latency unit between NREQ requesters,
// with tagged responses and a drain-and-hold flush handshake.
module inst_share_arb
  import inst_share_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  WIDTH = 10,
  parameter int  LAT   = 2,
  parameter type OUT_t = logic [WIDTH-1:0],
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [WIDTH-1:0]           unit_i,
  input  OUT_t                       unit_o,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output OUT_t                       rsp_data,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       busy
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  rr_pick_t       pick;
  logic           arb_en;
  logic           hs;
  tag_t           push_tag;
  tag_t           head_tag;
  logic           pipe_empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_ready    = '0;
    unit_i       = '0;
    pick         = rr_pick(MAX_REQ'(req_valid), MAX_IDW'(rr_ptr), NREQ);
    grant        = IDW'(pick.idx);
    // Flush suppresses grants in the very cycle it is first seen.
    arb_en       = !rst && (state == RUN) && !flush_req;
    hs           = arb_en && pick.found;
    if (hs) begin
      req_ready[grant] = 1'b1;
      unit_i           = req_data[grant];
    end
    push_tag.vld = hs;
    push_tag.id  = grant;
  end

  always_ff @(posedge clk) begin
    if (rst)     rr_ptr <= IDW'(NREQ - 1);
    else if (hs) rr_ptr <= grant;
  end

  inst_share_tagpipe #(.LAT(LAT), .IDW(IDW)) u_tagpipe (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_tag.vld),
    .push_id  (push_tag.id),
    .out_vld  (head_tag.vld),
    .out_id   (head_tag.id),
    .empty    (pipe_empty)
  );

  assign busy = !pipe_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= head_tag.vld;
      if (head_tag.vld) begin
        rsp_id   <= head_tag.id;
        rsp_data <= unit_o;
      end
    end
  end

  // An empty tag pipe means the last response is already in the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        RUN:   if (flush_req) state <= DRAIN;
        DRAIN: if (pipe_empty) begin
                 state      <= HOLD;
                 flush_done <= 1'b1;
               end
        HOLD:  if (!flush_req) begin
                 state      <= RUN;
                 flush_done <= 1'b0;
               end
        default: begin
                 state      <= RUN;
                 flush_done <= 1'b0;
               end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready));
      assert (int'(rsp_id) < NREQ);
    end
  end

endmodule

// File: tb/tb_inst_share_arb.sv
// Directed bench for inst_share_arb: a NREQ=4/LAT=2 build and a NREQ=3/LAT=1 build.
module tb_inst_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Build A: NREQ=4, LAT=2
  logic            a_rst, a_flush_req, a_rsp_valid, a_flush_done, a_busy;
  logic [3:0]      a_req_valid, a_req_ready;
  logic [3:0][9:0] a_req_data;
  logic [9:0]      a_unit_i, a_unit_o, a_rsp_data;
  logic [1:0]      a_rsp_id;
  logic [9:0]      a_upipe [2];

  inst_share_arb #(.NREQ(4), .WIDTH(10), .LAT(2)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_data(a_req_data), .unit_i(a_unit_i), .unit_o(a_unit_o),
    .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data),
    .flush_req(a_flush_req), .flush_done(a_flush_done), .busy(a_busy)
  );

  // Build B: NREQ=3, LAT=1
  logic            b_rst, b_flush_req, b_rsp_valid, b_flush_done, b_busy;
  logic [2:0]      b_req_valid, b_req_ready;
  logic [2:0][9:0] b_req_data;
  logic [9:0]      b_unit_i, b_unit_o, b_rsp_data;
  logic [1:0]      b_rsp_id;
  logic [9:0]      b_upipe;

  inst_share_arb #(.NREQ(3), .WIDTH(10), .LAT(1)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .unit_i(b_unit_i), .unit_o(b_unit_o),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .flush_req(b_flush_req), .flush_done(b_flush_done), .busy(b_busy)
  );

  // Shared-unit models: result = operand + 7, delayed by LAT cycles.
  always @(posedge clk) begin
    a_upipe[0] <= a_unit_i;
    a_upipe[1] <= a_upipe[0];
    b_upipe    <= b_unit_i;
  end
  assign a_unit_o = a_upipe[1] + 10'd7;
  assign b_unit_o = b_upipe + 10'd7;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_reset();
    a_rst       = 1'b1;
    a_req_valid = '0;
    a_flush_req = 1'b0;
    tick();
    tick();
    a_rst = 1'b0;
  endtask

  logic [3:0] s3_v [6] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010};
  logic [3:0] s3_r [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
  logic [3:0] s5_r [6] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    for (int i = 0; i < 4; i++) a_req_data[i] = 10'(100 + i);
    for (int i = 0; i < 3; i++) b_req_data[i] = 10'(200 + i);
    b_rst       = 1'b1;
    b_req_valid = '0;
    b_flush_req = 1'b0;

    // Reset values
    a_reset();
    check("rst ready", a_req_ready, 0);
    check("rst unit_i", a_unit_i, 0);
    check("rst rsp_valid", a_rsp_valid, 0);
    check("rst rsp_id", a_rsp_id, 0);
    check("rst rsp_data", a_rsp_data, 0);
    check("rst flush_done", a_flush_done, 0);
    check("rst busy", a_busy, 0);

    // Single requester 0 with operand 5
    a_req_data[0] = 10'd5;
    a_req_valid   = 4'b0001;
    #1;
    check("s1 ready", a_req_ready, 4'b0001);
    check("s1 unit_i", a_unit_i, 5);
    tick();
    a_req_valid = '0;
    check("s1 busy+1", a_busy, 1);
    check("s1 rsp_valid+1", a_rsp_valid, 0);
    tick();
    check("s1 rsp_valid+2", a_rsp_valid, 0);
    tick();
    check("s1 rsp_valid+3", a_rsp_valid, 1);
    check("s1 rsp_id", a_rsp_id, 0);
    check("s1 rsp_data", a_rsp_data, 12);
    check("s1 busy+3", a_busy, 0);
    tick();
    check("s1 rsp_valid+4", a_rsp_valid, 0);
    check("s1 rsp_data hold", a_rsp_data, 12);
    a_req_data[0] = 10'd100;

    // All four requesting for 8 cycles, then drain
    a_reset();
    for (int c = 0; c < 12; c++) begin
      a_req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        check($sformatf("s2 ready c%0d", c), a_req_ready, 1 << (c % 4));
        check($sformatf("s2 unit_i c%0d", c), a_unit_i, 100 + c % 4);
      end else begin
        check($sformatf("s2 ready c%0d", c), a_req_ready, 0);
      end
      check($sformatf("s2 rsp_valid c%0d", c), a_rsp_valid, (c >= 3 && c < 11) ? 1 : 0);
      if (c >= 3 && c < 11) begin
        check($sformatf("s2 rsp_id c%0d", c), a_rsp_id, (c - 3) % 4);
        check($sformatf("s2 rsp_data c%0d", c), a_rsp_data, 107 + (c - 3) % 4);
      end
      tick();
    end

    // Requesters 1 and 3, with rr_ptr set to 1 by the first grant
    a_reset();
    for (int c = 0; c < 6; c++) begin
      a_req_valid = s3_v[c];
      #1;
      check($sformatf("s3 ready c%0d", c), a_req_ready, s3_r[c]);
      tick();
    end

    // Flush with two issues in flight
    a_reset();
    for (int c = 0; c < 10; c++) begin
      a_req_valid = 4'hF;
      a_flush_req = (c >= 2 && c <= 7);
      #1;
      check($sformatf("s4 ready c%0d", c), a_req_ready,
            (c == 0) ? 1 : (c == 1) ? 2 : (c == 9) ? 4 : 0);
      check($sformatf("s4 flush_done c%0d", c), a_flush_done, (c >= 5 && c <= 8) ? 1 : 0);
      check($sformatf("s4 rsp_valid c%0d", c), a_rsp_valid, (c == 3 || c == 4) ? 1 : 0);
      if (c == 3 || c == 4) begin
        check($sformatf("s4 rsp_id c%0d", c), a_rsp_id, c - 3);
        check($sformatf("s4 busy c%0d", c), a_busy, (c == 3) ? 1 : 0);
      end
      tick();
    end

    // Reset pulse with two tags in flight
    a_reset();
    for (int c = 0; c < 6; c++) begin
      a_req_valid = 4'hF;
      a_rst       = (c == 2);
      #1;
      check($sformatf("s5 ready c%0d", c), a_req_ready, s5_r[c]);
      if (c >= 3) check($sformatf("s5 rsp_valid c%0d", c), a_rsp_valid, 0);
      tick();
    end
    a_rst       = 1'b0;
    a_req_valid = '0;

    // Build B: continuous requests, then a flush on an empty pipeline
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      b_req_valid = (c < 6 || c >= 9) ? 3'b111 : 3'b000;
      b_flush_req = (c >= 9);
      #1;
      check($sformatf("b ready c%0d", c), b_req_ready, (c < 6) ? (1 << (c % 3)) : 0);
      if (c < 6) check($sformatf("b unit_i c%0d", c), b_unit_i, 200 + c % 3);
      check($sformatf("b rsp_valid c%0d", c), b_rsp_valid, (c >= 2 && c < 8) ? 1 : 0);
      if (c >= 2 && c < 8) begin
        check($sformatf("b rsp_id c%0d", c), b_rsp_id, (c - 2) % 3);
        check($sformatf("b rsp_data c%0d", c), b_rsp_data, 207 + (c - 2) % 3);
      end
      if (c >= 9) begin
        check($sformatf("b flush_done c%0d", c), b_flush_done, (c == 11) ? 1 : 0);
        check($sformatf("b busy c%0d", c), b_busy, 0);
      end
      tick();
    end
    b_flush_req = 1'b0;
    b_req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
